// File: rtl/fi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fi_pkg
//  Description : Shared types for the fault-injection controller: fault-mode
//                and FSM state encodings plus the state-to-flag decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package fi_pkg;

    // Fault applied to the monitored bus while the fault is active
    typedef enum logic [1:0] {
        MODE_SA0    = 2'd0,
        MODE_SA1    = 2'd1,
        MODE_FLIP   = 2'd2,
        MODE_BRIDGE = 2'd3
    } fault_mode_e;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } fi_state_e;

    // Status flags, registered alongside the state so outputs come from flops
    typedef struct packed {
        logic ready;
        logic active;
        logic busy;
        logic done;
    } fi_flags_t;

    function automatic fi_flags_t state_flags(input fi_state_e s);
        fi_flags_t f;
        f.ready  = (s == ST_IDLE);
        f.active = (s == ST_ACTIVE);
        f.busy   = (s == ST_ARMED) || (s == ST_ACTIVE);
        f.done   = (s == ST_DONE);
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fi_mask_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fi_mask_gen
//  Description : Combinational fault overlay. Passes sig_in through untouched
//                unless active, then applies the selected fault to the target
//                bit(s). Out-of-range indices and a degenerate bridge
//                (sel == sel2) leave the bus unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
module fi_mask_gen
    import fi_pkg::*;
#(
    parameter int W     = 8,
    parameter int SEL_W = $clog2(W)
) (
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic [SEL_W-1:0] sel2,
    input  logic             active,
    input  logic [W-1:0]     sig_in,
    output logic [W-1:0]     sig_out
);

    logic w_bit_a;
    logic w_bit_b;
    logic w_a_ok;
    logic w_b_ok;
    logic w_bridge_ok;
    logic w_bridge_val;

    // Look up both bridge operands; an index matches only if it is below W
    always_comb begin
        w_bit_a = 1'b0;
        w_bit_b = 1'b0;
        w_a_ok  = 1'b0;
        w_b_ok  = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (sel == SEL_W'(i)) begin
                w_bit_a = sig_in[i];
                w_a_ok  = 1'b1;
            end
            if (sel2 == SEL_W'(i)) begin
                w_bit_b = sig_in[i];
                w_b_ok  = 1'b1;
            end
        end
    end

    assign w_bridge_ok  = w_a_ok && w_b_ok && (sel != sel2);
    assign w_bridge_val = w_bit_a & w_bit_b;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            localparam logic [SEL_W-1:0] c_idx = SEL_W'(gi);

            logic w_tgt;
            logic w_tgt2;
            logic w_bit;

            assign w_tgt  = (sel == c_idx);
            assign w_tgt2 = (sel2 == c_idx);

            // Per-bit overlay: pass-through unless this bit is a fault target
            always_comb begin
                w_bit = sig_in[gi];
                if (active) begin
                    case (fault_mode_e'(mode))
                        MODE_SA0:    if (w_tgt) w_bit = 1'b0;
                        MODE_SA1:    if (w_tgt) w_bit = 1'b1;
                        MODE_FLIP:   if (w_tgt) w_bit = ~sig_in[gi];
                        MODE_BRIDGE: if (w_bridge_ok && (w_tgt || w_tgt2)) w_bit = w_bridge_val;
                        default:     w_bit = sig_in[gi];
                    endcase
                end
            end

            assign sig_out[gi] = w_bit;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fault_inj_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fault_inj_ctrl
//  Description : Fault-injection controller. Accepts one fault configuration
//                at a time, waits cfg_delay cycles, applies the fault for
//                cfg_dur cycles (0 = until abort), then pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module fault_inj_ctrl
    import fi_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [1:0]            cfg_mode,
    input  logic [$clog2(W)-1:0]  cfg_sel,
    input  logic [$clog2(W)-1:0]  cfg_sel2,
    input  logic [CNT_W-1:0]      cfg_delay,
    input  logic [CNT_W-1:0]      cfg_dur,
    input  logic                  abort,
    input  logic [W-1:0]          sig_in,
    output logic [W-1:0]          sig_out,
    output logic                  active,
    output logic                  busy,
    output logic                  done
);

    localparam int               SEL_W = $clog2(W);
    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    fi_state_e          r_state;
    fi_flags_t          r_flags;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_dur;
    logic [1:0]         r_mode;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_sel2;

    // Counter holds "cycles remaining minus one" so a full-scale delay or
    // duration fits without an extra bit; it never decrements below zero.
    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : (v - c_one);
    endfunction

    // Sequencing FSM: IDLE -> (ARMED) -> ACTIVE -> DONE -> IDLE, abortable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_flags <= state_flags(ST_IDLE);
            r_cnt   <= '0;
            r_dur   <= '0;
            r_mode  <= '0;
            r_sel   <= '0;
            r_sel2  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // abort is ignored here, so a simultaneous request wins
                    if (cfg_valid) begin
                        r_mode <= cfg_mode;
                        r_sel  <= cfg_sel;
                        r_sel2 <= cfg_sel2;
                        r_dur  <= cfg_dur;
                        if (cfg_delay == '0) begin
                            r_state <= ST_ACTIVE;
                            r_flags <= state_flags(ST_ACTIVE);
                            r_cnt   <= dec_sat(cfg_dur);
                        end else begin
                            r_state <= ST_ARMED;
                            r_flags <= state_flags(ST_ARMED);
                            r_cnt   <= dec_sat(cfg_delay);
                        end
                    end
                end
                ST_ARMED: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_flags <= state_flags(ST_IDLE);
                    end else if (r_cnt == '0) begin
                        r_state <= ST_ACTIVE;
                        r_flags <= state_flags(ST_ACTIVE);
                        r_cnt   <= dec_sat(r_dur);
                    end else begin
                        r_cnt <= dec_sat(r_cnt);
                    end
                end
                ST_ACTIVE: begin
                    if (abort) begin
                        r_state <= ST_IDLE;
                        r_flags <= state_flags(ST_IDLE);
                    end else if (r_dur != '0) begin
                        // zero duration means permanent: only abort leaves
                        if (r_cnt == '0) begin
                            r_state <= ST_DONE;
                            r_flags <= state_flags(ST_DONE);
                        end else begin
                            r_cnt <= dec_sat(r_cnt);
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_flags <= state_flags(ST_IDLE);
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_flags <= state_flags(ST_IDLE);
                end
            endcase
        end
    end

    assign cfg_ready = r_flags.ready;
    assign active    = r_flags.active;
    assign busy      = r_flags.busy;
    assign done      = r_flags.done;

    // active clears asynchronously on reset, so the overlay drops at once
    fi_mask_gen #(
        .W     (W),
        .SEL_W (SEL_W)
    ) u_mask_gen (
        .mode    (r_mode),
        .sel     (r_sel),
        .sel2    (r_sel2),
        .active  (r_flags.active),
        .sig_in  (sig_in),
        .sig_out (sig_out)
    );

endmodule
`default_nettype wire

// File: doc/fault_inj_ctrl.md
FAULT_INJ_CTRL -- requirements
Module: fault_inj_ctrl

Interface
REQ-001 Parameter: W, default 8, width of the monitored signal bus (W >= 2).
REQ-002 Parameter: CNT_W, default 16, width of the delay and duration counters.
REQ-003 Port: clk  in  1  single clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: cfg_valid  in  1  fault-configuration request.
REQ-006 Port: cfg_ready  out  1  controller can accept a configuration.
REQ-007 Port: cfg_mode  in  2  fault mode: 0=SA0, 1=SA1, 2=FLIP, 3=BRIDGE (wired-AND).
REQ-008 Port: cfg_sel  in  $clog2(W)  target bit index.
REQ-009 Port: cfg_sel2  in  $clog2(W)  bridge partner bit index (BRIDGE only).
REQ-010 Port: cfg_delay  in  CNT_W  cycles between acceptance and fault onset.
REQ-011 Port: cfg_dur  in  CNT_W  fault duration in cycles; 0 means permanent.
REQ-012 Port: abort  in  1  cancel a pending or active fault.
REQ-013 Port: sig_in  in  W  fault-free signal bus.
REQ-014 Port: sig_out  out  W  signal bus with the fault applied.
REQ-015 Port: active  out  1  the fault is currently applied to sig_out.
REQ-016 Port: busy  out  1  a fault is armed or active.
REQ-017 Port: done  out  1  one-cycle pulse when a finite fault expires.

Function
REQ-018 The FSM SHALL have the states IDLE, ARMED, ACTIVE and DONE.
REQ-019 cfg_ready SHALL be 1 only in IDLE; a configuration is accepted when cfg_valid and cfg_ready are both 1, and all cfg_* fields are registered on that edge.
REQ-020 On acceptance at edge T: if cfg_delay=0, the FSM SHALL enter ACTIVE at T; otherwise it SHALL enter ARMED and remain there exactly cfg_delay cycles before entering ACTIVE.
REQ-021 ACTIVE SHALL last exactly cfg_dur cycles, followed by one DONE cycle (done=1) and then IDLE.
REQ-022 With cfg_dur=0, ACTIVE SHALL persist until abort.
REQ-023 abort in ARMED or ACTIVE SHALL return the FSM to IDLE on the next edge with no done pulse; abort in IDLE or DONE SHALL be ignored.
REQ-024 If abort and cfg_valid are both 1 while in IDLE, the configuration SHALL be accepted.
REQ-025 Outputs SHALL be active=(state==ACTIVE), busy=(ARMED or ACTIVE), and done=(state==DONE).
REQ-026 sig_out SHALL be combinational from sig_in (zero latency): sig_out=sig_in whenever active=0.
REQ-027 When active=1: SA0 forces bit sel to 0; SA1 forces bit sel to 1; FLIP inverts bit sel; BRIDGE drives bits sel and sel2 to sig_in[sel]&sig_in[sel2].
REQ-028 BRIDGE with sel==sel2, or any index >= W, SHALL leave sig_out=sig_in, while timing still runs normally.
REQ-029 Counters SHALL saturate rather than wrap; the maximum cfg_delay and cfg_dur values (2^CNT_W-1) SHALL be honoured exactly.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE and clear the counters and the registered configuration, giving cfg_ready=1, active=0, busy=0, done=0, and sig_out=sig_in.
REQ-031 Reset asserted mid-fault SHALL remove the fault immediately, without waiting for a clock edge.

Structure
REQ-032 The package fi_pkg SHALL hold the fault-mode enum (SA0, SA1, FLIP, BRIDGE) and the FSM state enum.
REQ-033 A combinational sub-module fi_mask_gen (mode, sel, sel2, active, sig_in -> sig_out) SHALL implement REQ-026 to REQ-028.

Verification
REQ-034 W=8: SA0, sel=3, delay=2, dur=3, sig_in=8'hFF -> sig_out=8'hFF for 2 cycles, then 8'hF7 for 3 cycles, then done=1 for 1 cycle, then cfg_ready=1.
REQ-035 BRIDGE, sel=1, sel2=6, delay=0, dur=0, sig_in=8'h02 -> sig_out=8'h00 until abort, then 8'h02 with done=0.
REQ-036 FLIP, sel=0, dur=0, sig_in toggling 8'h00/8'h01 -> sig_out toggles 8'h01/8'h00; rst_n low mid-fault -> sig_out=sig_in with no clock edge required.
REQ-037 cfg_valid held high during ARMED -> not accepted (cfg_ready=0); a new fault is accepted in the first IDLE cycle after done.
REQ-038 BRIDGE with sel=sel2=4, delay=1, dur=2 -> active asserts for 2 cycles, sig_out=sig_in throughout, and done pulses once.
